// File: rtl/ring_scan_pkg.sv
// Shared definitions for the ring scan driver: FSM state codes, error counter
// width and a one-hot test used by the phase encoder.
package ring_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BLANK = 2'd1;
  localparam state_t DRIVE = 2'd2;
  localparam state_t FAULT = 2'd3;

  localparam int ERR_CNT_W    = 8;
  localparam int ONEHOT_MAX_W = 32;

  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
    logic [ONEHOT_MAX_W-1:0] low_cleared;
    low_cleared = vec & (vec - ONEHOT_MAX_W'(1));
    return (vec != '0) && (low_cleared == '0);
  endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational one-hot encoder: returns the set-bit index and whether the
// input has exactly one bit set. idx is meaningless when valid is low.
module onehot_to_idx
  import ring_scan_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [ONEHOT_MAX_W-1:0] vec_pad;

  // OR together the positions of all set bits; exact when the input is one-hot
  always_comb begin
    vec_pad            = '0;
    vec_pad[WIDTH-1:0] = vec;
    idx                = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = idx | IW'(i);
      end else begin
        idx = idx;
      end
    end
    valid = is_onehot(vec_pad);
  end

endmodule

// File: rtl/ring_scan_driver.sv
// Time-multiplexed slot driver fed by a one-hot ring counter: blanks between
// slots, swaps double-buffered slot data only at frame wrap, counts bad phases.
module ring_scan_driver
  import ring_scan_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DW          = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     phase,
  input  logic [WIDTH*DW-1:0]  digit_data,
  input  logic                 load,
  output logic [WIDTH-1:0]     sel,
  output logic [DW-1:0]        seg_data,
  output logic                 frame_done,
  output logic                 phase_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0]     phase_q, phase_d, cur_q, cur_d, sel_q, sel_d;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH*DW-1:0]  shadow_q, shadow_d, active_q, active_d;
  logic                 pending_q, pending_d, frame_done_q, frame_done_d;
  logic                 phase_err_q, phase_err_d;
  logic [DW-1:0]        seg_q, seg_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [IW-1:0]        ph_idx;
  logic                 ph_valid, ph_zero, take_s;

  onehot_to_idx #(.WIDTH(WIDTH), .IW(IW)) u_idx (
    .vec   (phase_q),
    .idx   (ph_idx),
    .valid (ph_valid)
  );

  assign ph_zero = (phase_q == '0);

  // Next state, slot acceptance, wrap-time buffer swap and fault accounting
  always_comb begin
    phase_d      = phase;
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    phase_err_d  = phase_err_q;
    err_count_d  = err_count_q;
    frame_done_d = 1'b0;
    take_s       = 1'b0;
    sel_d        = '0;
    seg_d        = '0;

    case (state_q)
      IDLE: begin
        if (ph_valid) begin
          take_s = 1'b1;
        end else if (ph_zero) begin
          state_d = IDLE;
        end else begin
          state_d = FAULT;
        end
      end
      BLANK: begin
        if (!ph_valid) begin
          state_d = FAULT;
        end else if (phase_q != cur_q) begin
          take_s       = 1'b1;
          frame_done_d = cur_q[WIDTH-1] & phase_q[0];
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DRIVE: begin
        if (phase_q == cur_q) begin
          state_d = DRIVE;
        end else if (ph_valid) begin
          take_s       = 1'b1;
          frame_done_d = cur_q[WIDTH-1] & phase_q[0];
        end else if (ph_zero) begin
          state_d = IDLE;
        end else begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (ph_valid) begin
          take_s = 1'b1;
        end else if (ph_zero) begin
          state_d = IDLE;
        end else begin
          state_d = FAULT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_s) begin
      cur_d   = phase_q;
      cnt_d   = CNT_RELOAD;
      state_d = (DEAD_CYCLES == 0) ? DRIVE : BLANK;
    end else begin
      cur_d = cur_q;
    end

    // A load on the swap edge still lands in shadow and re-arms pending
    if (frame_done_d && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      active_d = active_q;
    end
    if (load) begin
      shadow_d  = digit_data;
      pending_d = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end

    if ((state_d == FAULT) && (state_q != FAULT)) begin
      phase_err_d = 1'b1;
      err_count_d = (err_count_q == ERR_MAX) ? err_count_q : (err_count_q + ERR_ONE);
    end else begin
      phase_err_d = phase_err_q;
    end

    // In DRIVE phase_q always equals cur_d, so ph_idx selects the slot
    if (state_d == DRIVE) begin
      sel_d = cur_d;
      seg_d = active_d[int'(ph_idx)*DW +: DW];
    end else begin
      sel_d = '0;
      seg_d = '0;
    end
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      state_q      <= IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      sel_q        <= '0;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
      phase_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      phase_q      <= phase_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      phase_err_q  <= phase_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign sel        = sel_q;
  assign seg_data   = seg_q;
  assign frame_done = frame_done_q;
  assign phase_err  = phase_err_q;
  assign err_count  = err_count_q;

endmodule
